// File: rtl/wreg_pkg.sv
// ---------------------------------------------------------------------------
// wreg_pkg
// Shared constants and helpers for the weight register bank.
//   - default weight width and kernel size
//   - flattened-bus index helper (start bit of weight i)
//   - severity code reported for a swap error; the accelerator status
//     register uses the same encoding
// ---------------------------------------------------------------------------
package wreg_pkg;

    localparam int WREG_DATA_WIDTH_DEF = 16;
    localparam int WREG_N_WEIGHTS_DEF  = 9;

    typedef enum logic [1:0] {
        WREG_SEV_NONE  = 2'd0,
        WREG_SEV_WARN  = 2'd1,
        WREG_SEV_ERROR = 2'd2
    } wreg_sev_e;

    // A swap request on a partial kernel is recoverable (software reissues it).
    localparam wreg_sev_e WREG_SWAP_ERR_SEV = WREG_SEV_WARN;

    // Lowest bit of weight idx inside a flattened bus of width-bit weights.
    function automatic int wreg_flat_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/wreg_fill_ctrl.sv
// ---------------------------------------------------------------------------
// wreg_fill_ctrl
// Fill counter and command arbitration for the weight register bank.
// Ports:
//   i_clk, i_rst_n          : clock (state on falling edge), async active-low reset
//   i_clear, i_swap         : abort partial load / request shadow->active transfer
//   i_in_valid              : a weight is offered this edge
//   o_count, o_full         : words in shadow, shadow complete
//   o_in_ready              : shadow can accept a word (= !full)
//   o_load_en, o_load_idx   : write strobe and index for the shadow bank
//   o_swap_en               : copy shadow into active on this edge
//   o_swap_err              : registered one-cycle pulse for a swap on a partial kernel
// Priority on one edge: clear > swap > load.
// ---------------------------------------------------------------------------
module wreg_fill_ctrl
    import wreg_pkg::*;
#(
    parameter int N_WEIGHTS = WREG_N_WEIGHTS_DEF,
    parameter int CNT_WIDTH = $clog2(N_WEIGHTS + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_swap,
    input  logic                 i_in_valid,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_full,
    output logic                 o_in_ready,
    output logic                 o_load_en,
    output logic [CNT_WIDTH-1:0] o_load_idx,
    output logic                 o_swap_en,
    output logic                 o_swap_err
);

    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_swap_err;
    logic                 w_full;

    assign w_full     = (r_count == CNT_WIDTH'(N_WEIGHTS));
    assign o_full     = w_full;
    assign o_in_ready = !w_full;
    assign o_count    = r_count;
    assign o_load_idx = r_count;

    // Swap only on a complete kernel; a load can never coincide with a
    // successful swap because in_ready is low whenever full is high.
    assign o_swap_en  = !i_clear && i_swap && w_full;
    assign o_load_en  = !i_clear && i_in_valid && !w_full;
    assign o_swap_err = r_swap_err;

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count    <= '0;
            r_swap_err <= 1'b0;
        end else begin
            // A swap on a partial kernel flags an error but still lets a
            // simultaneous load through (e.g. swap+valid at N-1).
            r_swap_err <= !i_clear && i_swap && !w_full;
            if (i_clear || o_swap_en)
                r_count <= '0;
            else if (o_load_en)
                r_count <= r_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/wreg_bank.sv
// ---------------------------------------------------------------------------
// wreg_bank
// Double-buffered weight register bank. Weights stream serially into a
// shadow bank; a swap copies the complete kernel into the active bank that
// drives the multiplier array in parallel. All state changes on the falling
// edge of WREG_Clk; WREG_Reset is asynchronous, active-low.
// Ports:
//   WREG_Clk, WREG_Reset              : clock, reset
//   WREG_Clear                        : abort partial load (count -> 0)
//   WREG_In_Valid/In_Data/In_Ready    : serial weight handshake, index 0 first
//   WREG_Swap                         : shadow -> active transfer request
//   WREG_Full, WREG_Count             : shadow fill status
//   WREG_Active_Valid                 : active bank holds a complete kernel
//   WREG_Swap_Err                     : one-cycle pulse, swap on partial kernel
//   WREG_Output_Data                  : active weights, weight i at [i*W +: W]
// ---------------------------------------------------------------------------
module wreg_bank
    import wreg_pkg::*;
#(
    parameter int WREG_DATA_WIDTH = WREG_DATA_WIDTH_DEF,
    parameter int WREG_N_WEIGHTS  = WREG_N_WEIGHTS_DEF,
    parameter int WREG_CNT_WIDTH  = $clog2(WREG_N_WEIGHTS + 1)
) (
    input  logic                                  WREG_Clk,
    input  logic                                  WREG_Reset,
    input  logic                                  WREG_Clear,
    input  logic                                  WREG_In_Valid,
    input  logic [WREG_DATA_WIDTH-1:0]            WREG_In_Data,
    output logic                                  WREG_In_Ready,
    input  logic                                  WREG_Swap,
    output logic                                  WREG_Full,
    output logic [WREG_CNT_WIDTH-1:0]             WREG_Count,
    output logic                                  WREG_Active_Valid,
    output logic                                  WREG_Swap_Err,
    output logic [WREG_N_WEIGHTS*WREG_DATA_WIDTH-1:0] WREG_Output_Data
);

    logic                      w_load_en;
    logic [WREG_CNT_WIDTH-1:0] w_load_idx;
    logic                      w_swap_en;
    logic                      r_active_valid;

    wreg_fill_ctrl #(
        .N_WEIGHTS (WREG_N_WEIGHTS),
        .CNT_WIDTH (WREG_CNT_WIDTH)
    ) u_fill_ctrl (
        .i_clk      (WREG_Clk),
        .i_rst_n    (WREG_Reset),
        .i_clear    (WREG_Clear),
        .i_swap     (WREG_Swap),
        .i_in_valid (WREG_In_Valid),
        .o_count    (WREG_Count),
        .o_full     (WREG_Full),
        .o_in_ready (WREG_In_Ready),
        .o_load_en  (w_load_en),
        .o_load_idx (w_load_idx),
        .o_swap_en  (w_swap_en),
        .o_swap_err (WREG_Swap_Err)
    );

    // One shadow and one active register per weight. The active bank is
    // only written by a swap, so Output_Data is a pure register output.
    genvar gi;
    generate
        for (gi = 0; gi < WREG_N_WEIGHTS; gi++) begin : g_word
            logic [WREG_DATA_WIDTH-1:0] r_shadow;
            logic [WREG_DATA_WIDTH-1:0] r_active;

            always_ff @(negedge WREG_Clk or negedge WREG_Reset) begin
                if (!WREG_Reset)
                    r_shadow <= '0;
                else if (w_load_en && (w_load_idx == WREG_CNT_WIDTH'(gi)))
                    r_shadow <= WREG_In_Data;
            end

            always_ff @(negedge WREG_Clk or negedge WREG_Reset) begin
                if (!WREG_Reset)
                    r_active <= '0;
                else if (w_swap_en)
                    r_active <= r_shadow;
            end

            assign WREG_Output_Data[wreg_flat_lo(gi, WREG_DATA_WIDTH) +: WREG_DATA_WIDTH] = r_active;
        end
    endgenerate

    always_ff @(negedge WREG_Clk or negedge WREG_Reset) begin
        if (!WREG_Reset)
            r_active_valid <= 1'b0;
        else if (w_swap_en)
            r_active_valid <= 1'b1;
    end

    assign WREG_Active_Valid = r_active_valid;

endmodule
